// File: rtl/backtrack_ctrl.sv
// DPLL trail sequencer: serialises trail pushes, unwinds the trail on conflict
// back to the latest decision, flips it into a forced entry and resumes BCP.
module backtrack_ctrl #(
  parameter int VAR_W    = 9,
  parameter int BT_CNT_W = 16,
  parameter int TIMEOUT  = 64
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push_req,
  input  logic                push_type,
  input  logic                push_val,
  input  logic [VAR_W-1:0]    push_var,
  output logic                push_ack,
  input  logic                conflict,
  output logic                busy,
  output logic                tt_push,
  output logic                tt_pop,
  output logic                tt_type,
  output logic                tt_val,
  output logic [VAR_W-1:0]    tt_var,
  input  logic                tt_done,
  input  logic                tt_empty,
  input  logic                tt_type_out,
  input  logic                tt_val_out,
  input  logic [VAR_W-1:0]    tt_var_out,
  output logic                unassign_valid,
  output logic [VAR_W-1:0]    unassign_var,
  output logic                resume_valid,
  output logic [VAR_W-1:0]    resume_var,
  output logic                resume_val,
  output logic                unsat,
  output logic                err,
  output logic [BT_CNT_W-1:0] bt_count
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LIMIT = WAIT_W'(TIMEOUT - 1);
  localparam logic [BT_CNT_W-1:0] BT_MAX     = '1;

  typedef enum logic [2:0] {
    IDLE,
    PUSH_WAIT,
    POP_REQ,
    POP_WAIT,
    FLIP_WAIT,
    UNSAT
  } state_t;

  state_t state_reg, state_next;

  logic [WAIT_W-1:0] wait_reg, wait_next;
  logic [VAR_W-1:0]  flip_var_reg, flip_var_next;
  logic              flip_val_reg, flip_val_next;
  logic              in_wait;
  logic              timed_out;

  logic                push_ack_next;
  logic                busy_next;
  logic                tt_push_next;
  logic                tt_pop_next;
  logic                tt_type_next;
  logic                tt_val_next;
  logic [VAR_W-1:0]    tt_var_next;
  logic                unassign_valid_next;
  logic [VAR_W-1:0]    unassign_var_next;
  logic                resume_valid_next;
  logic [VAR_W-1:0]    resume_var_next;
  logic                resume_val_next;
  logic                unsat_next;
  logic                err_next;
  logic [BT_CNT_W-1:0] bt_count_next;

  assign in_wait   = (state_reg == PUSH_WAIT) || (state_reg == POP_WAIT) ||
                     (state_reg == FLIP_WAIT);
  // A completion arriving on the last allowed cycle still wins over the timeout.
  assign timed_out = in_wait && (wait_reg == WAIT_LIMIT) && !tt_done;

  always_comb begin
    state_next          = state_reg;
    flip_var_next       = flip_var_reg;
    flip_val_next       = flip_val_reg;
    push_ack_next       = 1'b0;
    tt_push_next        = 1'b0;
    tt_pop_next         = 1'b0;
    tt_type_next        = tt_type;
    tt_val_next         = tt_val;
    tt_var_next         = tt_var;
    unassign_valid_next = 1'b0;
    unassign_var_next   = unassign_var;
    resume_valid_next   = 1'b0;
    resume_var_next     = resume_var;
    resume_val_next     = resume_val;
    unsat_next          = unsat;
    err_next            = err;
    bt_count_next       = bt_count;

    case (state_reg)
      IDLE: begin
        if (conflict) begin
          state_next = POP_REQ;
        end else if (push_req) begin
          tt_push_next = 1'b1;
          tt_type_next = push_type;
          tt_val_next  = push_val;
          tt_var_next  = push_var;
          state_next   = PUSH_WAIT;
        end
      end

      PUSH_WAIT: begin
        if (tt_done) begin
          push_ack_next = 1'b1;
          state_next    = IDLE;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      POP_REQ: begin
        tt_pop_next = 1'b1;
        state_next  = POP_WAIT;
      end

      POP_WAIT: begin
        if (tt_done) begin
          if (tt_empty) begin
            unsat_next = 1'b1;
            state_next = UNSAT;
          end else begin
            unassign_valid_next = 1'b1;
            unassign_var_next   = tt_var_out;
            if (tt_type_out) begin
              state_next = POP_REQ;
            end else begin
              // Decision reached: re-push it flipped as a forced entry.
              flip_var_next = tt_var_out;
              flip_val_next = ~tt_val_out;
              tt_push_next  = 1'b1;
              tt_type_next  = 1'b1;
              tt_val_next   = ~tt_val_out;
              tt_var_next   = tt_var_out;
              state_next    = FLIP_WAIT;
            end
          end
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      FLIP_WAIT: begin
        if (tt_done) begin
          resume_valid_next = 1'b1;
          resume_var_next   = flip_var_reg;
          resume_val_next   = flip_val_reg;
          if (bt_count != BT_MAX) begin
            bt_count_next = bt_count + 1'b1;
          end
          state_next = IDLE;
        end else if (timed_out) begin
          err_next   = 1'b1;
          state_next = IDLE;
        end
      end

      UNSAT: begin
        state_next = UNSAT;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (in_wait && (state_next == state_reg)) begin
      wait_next = wait_reg + 1'b1;
    end else begin
      wait_next = '0;
    end

    busy_next = (state_next != IDLE) && (state_next != UNSAT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      wait_reg       <= '0;
      flip_var_reg   <= '0;
      flip_val_reg   <= 1'b0;
      push_ack       <= 1'b0;
      busy           <= 1'b0;
      tt_push        <= 1'b0;
      tt_pop         <= 1'b0;
      tt_type        <= 1'b0;
      tt_val         <= 1'b0;
      tt_var         <= '0;
      unassign_valid <= 1'b0;
      unassign_var   <= '0;
      resume_valid   <= 1'b0;
      resume_var     <= '0;
      resume_val     <= 1'b0;
      unsat          <= 1'b0;
      err            <= 1'b0;
      bt_count       <= '0;
    end else begin
      state_reg      <= state_next;
      wait_reg       <= wait_next;
      flip_var_reg   <= flip_var_next;
      flip_val_reg   <= flip_val_next;
      push_ack       <= push_ack_next;
      busy           <= busy_next;
      tt_push        <= tt_push_next;
      tt_pop         <= tt_pop_next;
      tt_type        <= tt_type_next;
      tt_val         <= tt_val_next;
      tt_var         <= tt_var_next;
      unassign_valid <= unassign_valid_next;
      unassign_var   <= unassign_var_next;
      resume_valid   <= resume_valid_next;
      resume_var     <= resume_var_next;
      resume_val     <= resume_val_next;
      unsat          <= unsat_next;
      err            <= err_next;
      bt_count       <= bt_count_next;
    end
  end

endmodule

// File: tb/tb_backtrack_ctrl.sv
// Directed bench for backtrack_ctrl: a behavioural trace stack answers requests
// one cycle later, and scoreboard queues hold the expected unassign/resume pulses.
module tb_backtrack_ctrl;

  localparam int VAR_W    = 9;
  localparam int BT_CNT_W = 16;
  localparam int TIMEOUT  = 64;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                push_req = 1'b0;
  logic                push_type = 1'b0;
  logic                push_val = 1'b0;
  logic [VAR_W-1:0]    push_var = '0;
  logic                push_ack;
  logic                conflict = 1'b0;
  logic                busy;
  logic                tt_push;
  logic                tt_pop;
  logic                tt_type;
  logic                tt_val;
  logic [VAR_W-1:0]    tt_var;
  logic                tt_done = 1'b0;
  logic                tt_empty = 1'b0;
  logic                tt_type_out = 1'b0;
  logic                tt_val_out = 1'b0;
  logic [VAR_W-1:0]    tt_var_out = '0;
  logic                unassign_valid;
  logic [VAR_W-1:0]    unassign_var;
  logic                resume_valid;
  logic [VAR_W-1:0]    resume_var;
  logic                resume_val;
  logic                unsat;
  logic                err;
  logic [BT_CNT_W-1:0] bt_count;

  always #5 clk = ~clk;

  backtrack_ctrl #(
    .VAR_W(VAR_W),
    .BT_CNT_W(BT_CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .push_req(push_req),
    .push_type(push_type),
    .push_val(push_val),
    .push_var(push_var),
    .push_ack(push_ack),
    .conflict(conflict),
    .busy(busy),
    .tt_push(tt_push),
    .tt_pop(tt_pop),
    .tt_type(tt_type),
    .tt_val(tt_val),
    .tt_var(tt_var),
    .tt_done(tt_done),
    .tt_empty(tt_empty),
    .tt_type_out(tt_type_out),
    .tt_val_out(tt_val_out),
    .tt_var_out(tt_var_out),
    .unassign_valid(unassign_valid),
    .unassign_var(unassign_var),
    .resume_valid(resume_valid),
    .resume_var(resume_var),
    .resume_val(resume_val),
    .unsat(unsat),
    .err(err),
    .bt_count(bt_count)
  );

  typedef struct { logic typ; logic val; logic [VAR_W-1:0] vidx; } entry_t;
  typedef struct { int vidx; bit dec; bit flip_val; } unassign_t;
  typedef struct { int vidx; bit val; } resume_t;
  typedef enum int { K_REQ, K_FLIP, K_POP } kind_t;

  entry_t    stack_q[$];
  unassign_t exp_unassign_q[$];
  resume_t   exp_resume_q[$];

  int    checks = 0;
  int    failures = 0;
  bit    ack_due = 0;
  bit    resume_due = 0;
  bit    done_pending = 0;
  bit    hold_done = 0;
  kind_t pend_kind = K_REQ;
  int    exp_bt = 0;
  bit    exp_unsat = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: check pulses against the scoreboard, then let the stack respond.
  task automatic step();
    entry_t    e;
    unassign_t u;
    resume_t   r;
    @(posedge clk);
    #1;
    check("push_ack", push_ack, ack_due);
    check("resume_valid", resume_valid, resume_due);
    check("bt_count", bt_count, exp_bt);
    check("unsat", unsat, exp_unsat);
    if (resume_valid && exp_resume_q.size() > 0) begin
      r = exp_resume_q.pop_front();
      check("resume_var", resume_var, r.vidx);
      check("resume_val", resume_val, r.val);
    end
    if (unassign_valid) begin
      if (exp_unassign_q.size() == 0) begin
        check("unassign_valid", unassign_valid, 0);
      end else begin
        u = exp_unassign_q.pop_front();
        $display("unassign var=%0d", unassign_var);
        check("unassign_var", unassign_var, u.vidx);
        check("flip_tt_push", tt_push, u.dec);
        if (u.dec) begin
          check("flip_tt_type", tt_type, 1);
          check("flip_tt_val", tt_val, u.flip_val);
          check("flip_tt_var", tt_var, u.vidx);
        end
      end
    end

    ack_due    = 0;
    resume_due = 0;
    tt_done    = 1'b0;
    tt_empty   = 1'b0;
    if (done_pending && !hold_done) begin
      done_pending = 0;
      tt_done = 1'b1;
      case (pend_kind)
        K_REQ:  ack_due = 1;
        K_FLIP: begin
          resume_due = 1;
          exp_bt++;
        end
        default: begin
          if (stack_q.size() == 0) begin
            tt_empty  = 1'b1;
            exp_unsat = 1;
          end else begin
            e = stack_q.pop_back();
            tt_type_out = e.typ;
            tt_val_out  = e.val;
            tt_var_out  = e.vidx;
          end
        end
      endcase
    end
    if (tt_push) begin
      stack_q.push_back('{typ: tt_type, val: tt_val, vidx: tt_var});
      done_pending = 1;
      pend_kind = push_req ? K_REQ : K_FLIP;
    end
    if (tt_pop) begin
      done_pending = 1;
      pend_kind = K_POP;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    push_req = 1'b0;
    conflict = 1'b0;
    hold_done = 0;
    done_pending = 0;
    ack_due = 0;
    resume_due = 0;
    exp_bt = 0;
    exp_unsat = 0;
    tt_done = 1'b0;
    tt_empty = 1'b0;
    stack_q.delete();
    exp_unassign_q.delete();
    exp_resume_q.delete();
    step();
    check("reset_outputs",
          {push_ack, busy, tt_push, tt_pop, tt_type, tt_val, tt_var, unassign_valid,
           unassign_var, resume_valid, resume_var, resume_val, unsat, err, bt_count}, 0);
    reset = 1'b0;
    $display("reset applied");
  endtask

  task automatic do_push(input bit t, input bit v, input int vi);
    push_req  = 1'b1;
    push_type = t;
    push_val  = v;
    push_var  = VAR_W'(vi);
    step();
    check("tt_push", tt_push, 1);
    check("tt_type", tt_type, t);
    check("tt_val", tt_val, v);
    check("tt_var", tt_var, vi);
    step();
    check("tt_push_once", tt_push, 0);
    step();
    check("push_ack_seen", push_ack, 1);
    push_req = 1'b0;
    $display("push type=%0d val=%0d var=%0d acked=%0d", t, v, vi, push_ack);
  endtask

  task automatic start_conflict(input bit with_push);
    conflict = 1'b1;
    if (with_push) begin
      push_req  = 1'b1;
      push_type = 1'b0;
      push_val  = 1'b1;
      push_var  = VAR_W'(11);
    end
    step();
    conflict = 1'b0;
    push_req = 1'b0;
    check("tt_pop_early", tt_pop, 0);
    check("no_tt_push_a", tt_push, 0);
    step();
    check("tt_pop", tt_pop, 1);
    check("no_tt_push_b", tt_push, 0);
    $display("conflict with_push=%0d tt_pop=%0d", with_push, tt_pop);
  endtask

  task automatic settle(input string tag);
    for (int i = 0; i < 100; i++) begin
      step();
      if (!busy && !done_pending && exp_unassign_q.size() == 0 && exp_resume_q.size() == 0) break;
    end
    check({tag, "_busy"}, busy, 0);
    check({tag, "_unassign_left"}, exp_unassign_q.size(), 0);
    check({tag, "_resume_left"}, exp_resume_q.size(), 0);
  endtask

  initial begin
    // Reset state
    apply_reset();
    check("idle_busy", busy, 0);

    // Trail D(v5,1) F(v7,0) F(v9,1), then conflict unwinds to v5 and flips it
    do_push(0, 1, 5);
    do_push(1, 0, 7);
    do_push(1, 1, 9);
    exp_unassign_q.push_back('{9, 1'b0, 1'b0});
    exp_unassign_q.push_back('{7, 1'b0, 1'b0});
    exp_unassign_q.push_back('{5, 1'b1, 1'b0});
    exp_resume_q.push_back('{5, 1'b0});
    start_conflict(0);
    settle("backtrack");
    check("bt_count_one", bt_count, 1);

    // Stack never answers the pop: timeout after TIMEOUT waiting cycles
    hold_done = 1;
    start_conflict(0);
    repeat (TIMEOUT - 1) step();
    check("err_not_early", err, 0);
    check("busy_waiting", busy, 1);
    step();
    check("err_timeout", err, 1);
    check("busy_after_timeout", busy, 0);
    done_pending = 0;
    hold_done = 0;
    $display("timeout err=%0d busy=%0d", err, busy);

    // Conflict with simultaneous push_req: only the pop proceeds, forced F(v5,0)
    // unwinds and the then-empty stack ends in UNSAT
    exp_unassign_q.push_back('{5, 1'b0, 1'b0});
    start_conflict(1);
    settle("to_unsat");
    check("unsat_set", unsat, 1);
    check("err_sticky", err, 1);
    push_req = 1'b1;
    push_var = VAR_W'(3);
    repeat (4) begin
      step();
      check("unsat_no_tt_push", tt_push, 0);
    end
    push_req = 1'b0;
    conflict = 1'b1;
    step();
    conflict = 1'b0;
    repeat (3) begin
      step();
      check("unsat_no_tt_pop", tt_pop, 0);
    end
    check("unsat_sticky", unsat, 1);
    $display("unsat sticky unsat=%0d", unsat);

    // Conflict on an empty stack goes straight to UNSAT
    apply_reset();
    start_conflict(0);
    settle("empty");
    check("empty_unsat", unsat, 1);
    check("empty_err_clear", err, 0);
    $display("empty-stack conflict unsat=%0d", unsat);

    // Reset between two pops: nothing further after reset
    apply_reset();
    do_push(1, 1, 2);
    do_push(1, 0, 4);
    exp_unassign_q.push_back('{4, 1'b0, 1'b0});
    start_conflict(0);
    for (int i = 0; i < 20; i++) begin
      step();
      if (unassign_valid) break;
    end
    check("mid_unassign_seen", unassign_valid, 1);
    apply_reset();
    repeat (6) begin
      step();
      check("post_reset_tt_pop", tt_pop, 0);
      check("post_reset_busy", busy, 0);
    end
    $display("reset mid-backtrack busy=%0d", busy);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
